// File: rtl/plic_arb_pkg.sv
// Shared types for the PLIC claim/complete arbiter: operation codes, FSM states
// and a small wrap-around increment helper for the round-robin pointer.
package plic_arb_pkg;

    typedef enum logic {
        OP_CLAIM    = 1'b0,
        OP_COMPLETE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/plic_claim_arbiter_if.sv
// Gateway command/response bundle between the claim arbiter (master) and the
// PLIC gateway (slave). Names carry the arbiter-side direction suffix.
interface plic_claim_arbiter_if
    import plic_arb_pkg::*;
#(
    parameter int SrcIdW  = 5,
    parameter int TgtIdxW = 2
);
    logic               gw_valid_o;
    logic               gw_ready_i;
    op_e                gw_op_o;
    logic [TgtIdxW-1:0] gw_tgt_o;
    logic [SrcIdW-1:0]  gw_id_o;
    logic               gw_rsp_valid_i;
    logic [SrcIdW-1:0]  gw_rsp_id_i;

    modport master (
        output gw_valid_o, gw_op_o, gw_tgt_o, gw_id_o,
        input  gw_ready_i, gw_rsp_valid_i, gw_rsp_id_i
    );

    modport slave (
        input  gw_valid_o, gw_op_o, gw_tgt_o, gw_id_o,
        output gw_ready_i, gw_rsp_valid_i, gw_rsp_id_i
    );
endinterface

// File: rtl/rr_prio_pick.sv
// Round-robin winner search: first request at or above rr_i, otherwise the
// lowest request overall (wrap to index 0).
module rr_prio_pick #(
    parameter  int NumTgt  = 4,
    localparam int TgtIdxW = $clog2(NumTgt)
) (
    input  logic [NumTgt-1:0]  req_i,
    input  logic [TgtIdxW-1:0] rr_i,
    output logic [TgtIdxW-1:0] idx_o,
    output logic               empty_o
);
    logic [NumTgt-1:0]  upper;
    logic               hit_up;
    logic               hit_lo;
    logic [TgtIdxW-1:0] idx_up;
    logic [TgtIdxW-1:0] idx_lo;

    always_comb begin
        upper  = '0;
        hit_up = 1'b0;
        hit_lo = 1'b0;
        idx_up = '0;
        idx_lo = '0;
        for (int i = 0; i < NumTgt; i++) begin
            upper[i] = req_i[i] && (TgtIdxW'(i) >= rr_i);
        end
        // Scan downward so the last hit written is the lowest index.
        for (int i = NumTgt - 1; i >= 0; i--) begin
            if (upper[i]) begin
                idx_up = TgtIdxW'(i);
                hit_up = 1'b1;
            end
            if (req_i[i]) begin
                idx_lo = TgtIdxW'(i);
                hit_lo = 1'b1;
            end
        end
        idx_o   = hit_up ? idx_up : idx_lo;
        empty_o = !hit_lo;
    end
endmodule

// File: rtl/plic_claim_arbiter.sv
// Serialises per-hart claim/complete requests onto a single PLIC gateway port,
// one operation in flight, round-robin between harts.
//   state | meaning
//   IDLE  | waiting for any hart request
//   ISSUE | presenting latched command to the gateway
//   WAIT  | waiting for the gateway response pulse
//   RESP  | presenting response to the winning hart
module plic_claim_arbiter
    import plic_arb_pkg::*;
#(
    parameter  int NumTgt  = 4,
    parameter  int SrcIdW  = 5,
    localparam int TgtIdxW = $clog2(NumTgt)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumTgt-1:0]              req_valid_i,
    output logic [NumTgt-1:0]              req_ready_o,
    input  logic [NumTgt-1:0]              req_op_i,
    input  logic [NumTgt-1:0][SrcIdW-1:0]  req_id_i,
    output logic [NumTgt-1:0]              rsp_valid_o,
    input  logic [NumTgt-1:0]              rsp_ready_i,
    output logic [SrcIdW-1:0]              rsp_id_o,
    plic_claim_arbiter_if.master           gw,
    output logic                           busy_o,
    output logic                           err_o
);
    arb_state_e         state_q, state_d;
    logic [TgtIdxW-1:0] rr_q, rr_d;
    op_e                op_q, op_d;
    logic [SrcIdW-1:0]  id_q, id_d;
    logic [TgtIdxW-1:0] win_q, win_d;
    logic [SrcIdW-1:0]  rsp_id_q, rsp_id_d;
    logic               err_q, err_d;

    logic [TgtIdxW-1:0] pick_idx;
    logic               pick_empty;

    rr_prio_pick #(.NumTgt(NumTgt)) u_pick (
        .req_i   (req_valid_i),
        .rr_i    (rr_q),
        .idx_o   (pick_idx),
        .empty_o (pick_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            op_q     <= OP_CLAIM;
            id_q     <= '0;
            win_q    <= '0;
            rsp_id_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            op_q     <= op_d;
            id_q     <= id_d;
            win_q    <= win_d;
            rsp_id_q <= rsp_id_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        op_d     = op_q;
        id_d     = id_q;
        win_d    = win_q;
        rsp_id_d = rsp_id_q;
        // A gateway response we are not waiting for is a protocol violation.
        err_d    = err_q | (gw.gw_rsp_valid_i && (state_q != WAIT));
        unique case (state_q)
            IDLE: begin
                if (!pick_empty) begin
                    op_d    = op_e'(req_op_i[pick_idx]);
                    id_d    = req_id_i[pick_idx];
                    win_d   = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (gw.gw_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (gw.gw_rsp_valid_i) begin
                    rsp_id_d = gw.gw_rsp_id_i;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i[win_q]) begin
                    rr_d    = TgtIdxW'(wrap_inc(int'(win_q), NumTgt));
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o    = '0;
        rsp_valid_o    = '0;
        gw.gw_valid_o  = 1'b0;
        gw.gw_op_o     = OP_CLAIM;
        gw.gw_tgt_o    = '0;
        gw.gw_id_o     = '0;
        unique case (state_q)
            IDLE: begin
                // Gated by reset so no grant is seen while the block is held.
                if (!pick_empty) req_ready_o[pick_idx] = !rst_i;
            end
            ISSUE: begin
                gw.gw_valid_o = 1'b1;
                gw.gw_op_o    = op_q;
                gw.gw_tgt_o   = win_q;
                gw.gw_id_o    = id_q;
            end
            RESP:    rsp_valid_o[win_q] = 1'b1;
            default: ;
        endcase
    end

    assign rsp_id_o = rsp_id_q;
    assign busy_o   = (state_q != IDLE);
    assign err_o    = err_q;
endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Directed bench for plic_claim_arbiter: round-robin order, stalled gateway,
// stalled response, stray gateway response and mid-operation reset.
module tb_plic_claim_arbiter;
    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_op;
    logic [3:0][4:0]  req_id;
    logic [3:0]       rsp_ready;
    wire  [3:0]       req_ready;
    wire  [3:0]       rsp_valid;
    wire  [4:0]       rsp_id;
    wire              busy;
    wire              err;

    int checks   = 0;
    int failures = 0;
    int rsp_cnt [4];

    always #5 clk = ~clk;

    plic_claim_arbiter_if #(.SrcIdW(5), .TgtIdxW(2)) gw_if ();

    plic_claim_arbiter #(.NumTgt(4), .SrcIdW(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_id_i    (req_id),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .gw          (gw_if),
        .busy_o      (busy),
        .err_o       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One minimum-latency operation; w is the hand-computed expected winner.
    task automatic serve(input logic [3:0] valid, input logic [3:0] op, input logic [4:0] id,
                         input int w, input logic [4:0] ret, input string tag);
        req_valid = valid;
        req_op    = op;
        for (int i = 0; i < 4; i++) req_id[i] = id;
        #1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(1 << w));
        step();
        chk({tag, " gw_valid"}, 32'(gw_if.gw_valid_o), 32'd1);
        chk({tag, " gw_tgt"}, 32'(gw_if.gw_tgt_o), 32'(w));
        chk({tag, " gw_op"}, 32'(gw_if.gw_op_o), 32'(op[w]));
        if (op[w]) chk({tag, " gw_id"}, 32'(gw_if.gw_id_o), 32'(id));
        gw_if.gw_ready_i = 1'b1;
        step();
        gw_if.gw_ready_i = 1'b0;
        chk({tag, " wait gw_valid"}, 32'(gw_if.gw_valid_o), 32'd0);
        chk({tag, " wait busy"}, 32'(busy), 32'd1);
        gw_if.gw_rsp_valid_i = 1'b1;
        gw_if.gw_rsp_id_i    = ret;
        step();
        gw_if.gw_rsp_valid_i = 1'b0;
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1 << w));
        chk({tag, " rsp_id"}, 32'(rsp_id), 32'(ret));
        chk({tag, " resp req_ready"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++) rsp_cnt[i] += int'(rsp_valid[i]);
        rsp_ready = 4'(1 << w);
        step();
        rsp_ready = '0;
        req_valid = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, " gw_valid"}, 32'(gw_if.gw_valid_o), 32'd0);
        chk({tag, " gw_op"}, 32'(gw_if.gw_op_o), 32'd0);
        chk({tag, " gw_tgt"}, 32'(gw_if.gw_tgt_o), 32'd0);
        chk({tag, " gw_id"}, 32'(gw_if.gw_id_o), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        req_valid            = 4'hF;
        req_op               = '0;
        req_id               = '0;
        rsp_ready            = '0;
        gw_if.gw_ready_i     = 1'b0;
        gw_if.gw_rsp_valid_i = 1'b0;
        gw_if.gw_rsp_id_i    = '0;
        for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;

        step();
        step();
        chk_reset_outputs("reset");
        rst       = 1'b0;
        req_valid = '0;
        step();
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle req_ready", 32'(req_ready), 32'd0);

        // All four claim continuously: 0,1,2,3,0; target 2 gets ID 0 back.
        serve(4'hF, 4'h0, 5'd0, 0, 5'd11, "rr_a0");
        serve(4'hF, 4'h0, 5'd0, 1, 5'd12, "rr_a1");
        serve(4'hF, 4'h0, 5'd0, 2, 5'd0,  "rr_a2");
        serve(4'hF, 4'h0, 5'd0, 3, 5'd13, "rr_a3");
        for (int i = 0; i < 4; i++) chk($sformatf("rsp_cnt t%0d", i), 32'(rsp_cnt[i]), 32'd1);
        serve(4'hF, 4'h0, 5'd0, 0, 5'd14, "rr_a4");
        chk("rsp_cnt t0 after wrap", 32'(rsp_cnt[0]), 32'd2);

        // Bring rr to 2, then only targets 1 and 3 request.
        serve(4'b0010, 4'h0, 5'd0, 1, 5'd15, "solo1");
        serve(4'b1010, 4'h0, 5'd0, 3, 5'd16, "odd3a");
        serve(4'b1010, 4'h0, 5'd0, 1, 5'd17, "odd1");
        serve(4'b1010, 4'h0, 5'd0, 3, 5'd18, "odd3b");

        // Target 2 completes ID 7 with gateway stalled for 5 cycles.
        req_valid = 4'b0100;
        req_op    = 4'b0100;
        req_id    = '0;
        req_id[2] = 5'd7;
        #1;
        chk("cmp req_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        req_op    = '0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d gw_valid", k), 32'(gw_if.gw_valid_o), 32'd1);
            chk($sformatf("stall%0d gw_op", k), 32'(gw_if.gw_op_o), 32'd1);
            chk($sformatf("stall%0d gw_tgt", k), 32'(gw_if.gw_tgt_o), 32'd2);
            chk($sformatf("stall%0d gw_id", k), 32'(gw_if.gw_id_o), 32'd7);
            step();
        end
        gw_if.gw_ready_i = 1'b1;
        chk("stall accept gw_valid", 32'(gw_if.gw_valid_o), 32'd1);
        step();
        gw_if.gw_ready_i = 1'b0;
        chk("cmp wait gw_valid", 32'(gw_if.gw_valid_o), 32'd0);
        step();
        chk("cmp wait busy", 32'(busy), 32'd1);
        chk("cmp wait rsp_valid", 32'(rsp_valid), 32'd0);
        gw_if.gw_rsp_valid_i = 1'b1;
        gw_if.gw_rsp_id_i    = 5'd7;
        step();
        gw_if.gw_rsp_valid_i = 1'b0;

        // Response held off 10 cycles while others request and poke rsp_ready.
        req_valid = 4'b1011;
        rsp_ready = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("hold%0d req_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("hold%0d rsp_valid", k), 32'(rsp_valid), 32'b0100);
            chk($sformatf("hold%0d rsp_id", k), 32'(rsp_id), 32'd7);
            step();
        end
        rsp_ready = 4'b0100;
        step();
        rsp_ready = '0;
        serve(4'b1011, 4'h0, 5'd0, 3, 5'd19, "after_hold");
        chk("stray rsp_ready err", 32'(err), 32'd0);

        // Stray gateway response in IDLE.
        gw_if.gw_rsp_valid_i = 1'b1;
        gw_if.gw_rsp_id_i    = 5'd5;
        #1;
        chk("stray pre err", 32'(err), 32'd0);
        step();
        gw_if.gw_rsp_valid_i = 1'b0;
        chk("stray err set", 32'(err), 32'd1);
        chk("stray busy", 32'(busy), 32'd0);
        chk("stray rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        step();
        chk("stray err sticky", 32'(err), 32'd1);
        chk("stray busy later", 32'(busy), 32'd0);
        serve(4'b0001, 4'h0, 5'd0, 0, 5'd9, "post_err");
        chk("post_err err", 32'(err), 32'd1);

        // Reset while waiting on the gateway; rr would otherwise favour target 1.
        req_valid = 4'b0100;
        #1;
        chk("rst op req_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid        = '0;
        gw_if.gw_ready_i = 1'b1;
        step();
        gw_if.gw_ready_i = 1'b0;
        chk("rst op busy", 32'(busy), 32'd1);
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        chk_reset_outputs("midrst");
        step();
        rst = 1'b0;
        serve(4'hF, 4'h0, 5'd0, 0, 5'd21, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/plic_claim_arbiter.md
PLIC_CLAIM_ARBITER -- requirements
Module: plic_claim_arbiter

Interface
REQ-001 Parameter NumTgt, default 4, number of target contexts (harts) sharing the gateway port; legal range 2..16.
REQ-002 Parameter SrcIdW, default 5, width of interrupt source ID.
REQ-003 Parameter TgtIdxW, default $clog2(NumTgt), derived, not overridden.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  in  NumTgt  per-target operation request.
REQ-007 req_ready_o  out  NumTgt  per-target request accepted (one-hot or zero).
REQ-008 req_op_i  in  NumTgt  per-target op: 0 = claim, 1 = complete.
REQ-009 req_id_i  in  NumTgt x SrcIdW  per-target source ID (complete only).
REQ-010 rsp_valid_o  out  NumTgt  per-target response valid (one-hot or zero).
REQ-011 rsp_ready_i  in  NumTgt  per-target response accepted.
REQ-012 rsp_id_o  out  SrcIdW  shared response ID (claimed ID, or echoed ID for complete).
REQ-013 gw_valid_o / gw_ready_i  out/in  1 / 1  gateway command handshake.
REQ-014 gw_op_o, gw_tgt_o, gw_id_o  out  1, TgtIdxW, SrcIdW  gateway command payload.
REQ-015 gw_rsp_valid_i, gw_rsp_id_i  in  1, SrcIdW  gateway response (one-cycle pulse).
REQ-016 busy_o  out  1  high in any state except IDLE.
REQ-017 err_o  out  1  sticky protocol error flag.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-019 IDLE: if any req_valid_i, select winner W as the first set bit at or above rr_q, wrapping to index 0; assert req_ready_o[W] combinationally that cycle; latch op, ID, W; go to ISSUE.
REQ-020 IDLE with no request: stay in IDLE, all outputs inactive.
REQ-021 ISSUE: gw_valid_o=1 with latched payload, held stable until gw_ready_i; on handshake go to WAIT. gw_valid_o first rises the cycle after acceptance.
REQ-022 WAIT: on gw_rsp_valid_i latch gw_rsp_id_i into rsp_id_o and go to RESP.
REQ-023 RESP: rsp_valid_o[W]=1, rsp_id_o stable until rsp_ready_i[W]; on handshake set rr_q=(W+1) mod NumTgt and go to IDLE.
REQ-024 rr_q wraps: W=NumTgt-1 gives rr_q=0.
REQ-025 Minimum round trip: request at cycle 0, gw_valid_o at 1, gw_rsp at 2 at the earliest, rsp_valid_o at 3, next acceptance at 4 at the earliest.
REQ-026 Requesters whose req_valid_i is deasserted before being granted are dropped with no side effect; a granted request is fully owned by the arbiter.
REQ-027 gw_rsp_valid_i outside WAIT is ignored and sets err_o; err_o clears only on reset.
REQ-028 rsp_ready_i on a non-winner index, or in any state other than RESP, is ignored and has no effect on err_o.
REQ-029 A claim that returns ID 0 (nothing pending) is a normal response, passed through unchanged.

Reset
REQ-030 Asserting rst_i at any time, including mid-operation, immediately forces state=IDLE, rr_q=0, err_o=0 and clears latched op/ID/W; the aborted operation is not resumed.
REQ-031 Reset values: req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, gw_valid_o=0, gw_op_o=0, gw_tgt_o=0, gw_id_o=0, busy_o=0, err_o=0.

Structure
REQ-032 Shared package plic_arb_pkg holds op_e (OP_CLAIM, OP_COMPLETE) and arb_state_e (IDLE, ISSUE, WAIT, RESP).
REQ-033 One combinational sub-module, rr_prio_pick (inputs req vector and rr_q; outputs winner index and empty flag), implements the masked upper/lower search.
REQ-034 All state registers reset asynchronously on rst_i; there is no other clock or reset domain.

Verification
REQ-035 NumTgt=4, rr_q=0, all four targets claim every cycle, gateway ready immediately -> grant order 0,1,2,3,0; each target sees rsp_valid_o exactly once per 4 operations.
REQ-036 Only targets 1 and 3 request, rr_q=2 -> 3 granted first, then 1, then 3; rr_q after each = 0, 2, 0.
REQ-037 Target 2 completes ID 7, gw_ready_i held low 5 cycles -> gw_valid_o high 5 cycles with gw_op_o=1, gw_tgt_o=2, gw_id_o=7 stable; rsp_id_o=7 to target 2.
REQ-038 gw_rsp_valid_i pulsed in IDLE -> err_o=1 and stays 1; FSM stays in IDLE; next claim completes normally.
REQ-039 rst_i asserted in WAIT -> outputs at reset values in the same cycle, busy_o=0; after release a new request is accepted starting from index 0.
REQ-040 rsp_ready_i held low 10 cycles in RESP with other targets requesting -> no req_ready_o asserted and rsp_id_o stable throughout.
